// File: rtl/lcd_refresh_if.sv
// Frame/strobe inputs and HD44780 4-bit panel pins of the LCD writer.
interface lcd_refresh_if;
  logic         cls;
  logic [255:0] strdata;
  logic         LCDE;
  logic         LCDRS;
  logic         LCDRW;
  logic [3:0]   LCDDAT;
  logic         busy;
  logic         done;

  modport master (
    output cls, strdata,
    input  LCDE, LCDRS, LCDRW, LCDDAT, busy, done
  );

  modport slave (
    input  cls, strdata,
    output LCDE, LCDRS, LCDRW, LCDDAT, busy, done
  );
endinterface

// File: rtl/lcd_refresh.sv
// Character-LCD writer: HD44780 4-bit power-on init, then rewrites both lines from a frame snapshot per cls.
// Refresh starts the cycle after cls is seen in IDLE; cls arriving while busy collapses into one pending refresh.
module lcd_refresh #(
  parameter int POWERUP_CYC    = 750000,
  parameter int INIT_LONG_CYC  = 205000,
  parameter int INIT_SHORT_CYC = 5000,
  parameter int E_PULSE_CYC    = 12,
  parameter int NIBBLE_GAP_CYC = 50,
  parameter int CMD_CYC        = 2000,
  parameter int CLEAR_CYC      = 82000
) (
  input  logic         CCLK,
  input  logic         rst_n,
  lcd_refresh_if.slave lcd
);

  localparam int M1   = (POWERUP_CYC > INIT_LONG_CYC) ? POWERUP_CYC : INIT_LONG_CYC;
  localparam int M2   = (M1 > INIT_SHORT_CYC) ? M1 : INIT_SHORT_CYC;
  localparam int M3   = (M2 > E_PULSE_CYC) ? M2 : E_PULSE_CYC;
  localparam int M4   = (M3 > NIBBLE_GAP_CYC) ? M3 : NIBBLE_GAP_CYC;
  localparam int M5   = (M4 > CMD_CYC) ? M4 : CMD_CYC;
  localparam int MAXC = (M5 > CLEAR_CYC) ? M5 : CLEAR_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t PW_LAST    = cnt_t'(POWERUP_CYC - 1);
  localparam cnt_t LONG_LAST  = cnt_t'(INIT_LONG_CYC - 1);
  localparam cnt_t SHORT_LAST = cnt_t'(INIT_SHORT_CYC - 1);
  localparam cnt_t E_LAST     = cnt_t'(E_PULSE_CYC - 1);
  localparam cnt_t GAP_LAST   = cnt_t'(NIBBLE_GAP_CYC - 1);
  localparam cnt_t CMD_LAST   = cnt_t'(CMD_CYC - 1);
  localparam cnt_t CLEAR_LAST = cnt_t'(CLEAR_CYC - 1);

  typedef enum logic [2:0] {PWRUP, INIT_NIB, INIT_CFG, IDLE, REFRESH} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_HIGH, PH_LOW, PH_WAIT} phase_t;

  // Byte sent at step idx of a stage; single-nibble init writes carry their nibble in [7:4].
  function automatic logic [7:0] step_byte(state_t st, logic [5:0] idx, logic [255:0] snap);
    logic [7:0] b;
    logic [4:0] c;
    b = 8'h00;
    c = 5'd0;
    case (st)
      INIT_NIB: b = (idx == 6'd3) ? 8'h20 : 8'h30;
      INIT_CFG: begin
        case (idx[1:0])
          2'd0:    b = 8'h28;
          2'd1:    b = 8'h06;
          2'd2:    b = 8'h0C;
          default: b = 8'h01;
        endcase
      end
      REFRESH: begin
        if (idx == 6'd0) begin
          b = 8'h80;
        end else if (idx == 6'd17) begin
          b = 8'hC0;
        end else begin
          c = idx[4:0] - ((idx < 6'd17) ? 5'd1 : 5'd2);
          b = snap[{~c, 3'b000} +: 8];
        end
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic step_rs(state_t st, logic [5:0] idx);
    return (st == REFRESH) && (idx != 6'd0) && (idx != 6'd17);
  endfunction

  function automatic logic step_last(state_t st, logic [5:0] idx);
    logic l;
    case (st)
      INIT_NIB, INIT_CFG: l = (idx == 6'd3);
      REFRESH:            l = (idx == 6'd33);
      default:            l = 1'b0;
    endcase
    return l;
  endfunction

  function automatic cnt_t step_wait(state_t st, logic [5:0] idx, logic [7:0] b, logic rs);
    cnt_t w;
    if (st == INIT_NIB) begin
      w = (idx == 6'd0) ? LONG_LAST : (idx == 6'd3) ? CMD_LAST : SHORT_LAST;
    end else begin
      w = (!rs && b == 8'h01) ? CLEAR_LAST : CMD_LAST;
    end
    return w;
  endfunction

  state_t       st_q;
  phase_t       ph_q;
  logic [5:0]   idx_q;
  logic         nib_q;
  logic         single_q;
  cnt_t         cnt_q;
  cnt_t         wait_q;
  logic [3:0]   lo_q;
  logic [255:0] snap_q;
  logic         pending_q;
  logic         e_q;
  logic         rs_q;
  logic [3:0]   dat_q;
  logic         busy_q;
  logic         done_q;

  state_t       ld_st;
  logic [5:0]   ld_idx;
  logic [7:0]   ld_byte;
  logic         ld_rs;
  cnt_t         ld_wait;
  logic         cur_last;
  logic         wait_end;
  logic         adv;

  assign cur_last = step_last(st_q, idx_q);
  assign wait_end = (ph_q == PH_WAIT) && (cnt_q == wait_q);

  // Next step to launch: first step of the following stage, or the next index in this one.
  always_comb begin
    ld_st  = st_q;
    ld_idx = idx_q + 6'd1;
    adv    = 1'b0;
    case (st_q)
      PWRUP: begin
        ld_st  = INIT_NIB;
        ld_idx = 6'd0;
        adv    = (cnt_q == PW_LAST);
      end
      IDLE: begin
        ld_st  = REFRESH;
        ld_idx = 6'd0;
        adv    = lcd.cls || pending_q;
      end
      default: begin
        if (st_q == INIT_NIB && cur_last) begin
          ld_st  = INIT_CFG;
          ld_idx = 6'd0;
        end
        adv = wait_end && (!cur_last || st_q == INIT_NIB);
      end
    endcase
    ld_byte = step_byte(ld_st, ld_idx, snap_q);
    ld_rs   = step_rs(ld_st, ld_idx);
    ld_wait = step_wait(ld_st, ld_idx, ld_byte, ld_rs);
  end

  always_ff @(posedge CCLK or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= PWRUP;
      ph_q      <= PH_SETUP;
      idx_q     <= '0;
      nib_q     <= 1'b0;
      single_q  <= 1'b0;
      cnt_q     <= '0;
      wait_q    <= '0;
      lo_q      <= '0;
      snap_q    <= '0;
      pending_q <= 1'b0;
      e_q       <= 1'b0;
      rs_q      <= 1'b0;
      dat_q     <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (lcd.cls && st_q != IDLE) pending_q <= 1'b1;
      if (adv) begin
        st_q     <= ld_st;
        idx_q    <= ld_idx;
        ph_q     <= PH_SETUP;
        cnt_q    <= '0;
        nib_q    <= 1'b0;
        dat_q    <= ld_byte[7:4];
        lo_q     <= ld_byte[3:0];
        rs_q     <= ld_rs;
        single_q <= (ld_st == INIT_NIB);
        wait_q   <= ld_wait;
        if (st_q == IDLE) begin
          snap_q    <= lcd.strdata;
          pending_q <= 1'b0;
          busy_q    <= 1'b1;
        end
      end else begin
        case (st_q)
          PWRUP: cnt_q <= cnt_q + cnt_t'(1);
          IDLE:  cnt_q <= '0;
          default: begin
            case (ph_q)
              PH_SETUP: begin
                ph_q <= PH_HIGH;
                e_q  <= 1'b1;
              end
              PH_HIGH: begin
                if (cnt_q == E_LAST) begin
                  ph_q  <= PH_LOW;
                  e_q   <= 1'b0;
                  cnt_q <= '0;
                end else begin
                  cnt_q <= cnt_q + cnt_t'(1);
                end
              end
              PH_LOW: begin
                if (cnt_q == GAP_LAST) begin
                  cnt_q <= '0;
                  if (!single_q && !nib_q) begin
                    nib_q <= 1'b1;
                    dat_q <= lo_q;
                    ph_q  <= PH_SETUP;
                  end else begin
                    ph_q <= PH_WAIT;
                  end
                end else begin
                  cnt_q <= cnt_q + cnt_t'(1);
                end
              end
              default: begin
                // Only the final step of INIT_CFG or REFRESH ends its wait without advancing.
                if (wait_end) begin
                  st_q   <= IDLE;
                  cnt_q  <= '0;
                  busy_q <= 1'b0;
                  done_q <= (st_q == REFRESH);
                end else begin
                  cnt_q <= cnt_q + cnt_t'(1);
                end
              end
            endcase
          end
        endcase
      end
    end
  end

  assign lcd.LCDE   = e_q;
  assign lcd.LCDRS  = rs_q;
  assign lcd.LCDRW  = 1'b0;
  assign lcd.LCDDAT = dat_q;
  assign lcd.busy   = busy_q;
  assign lcd.done   = done_q;

endmodule

// File: tb/tb_lcd_refresh.sv
// Bench for lcd_refresh: nibble stream and busy/done timing compared with a byte-list reference model.
module tb_lcd_refresh;
  localparam int PW = 20, IL = 10, IS = 5, EP = 2, GP = 2, CC = 4, CL = 8;
  localparam int N  = 1 + EP + GP;

  logic CCLK  = 1'b0;
  logic rst_n = 1'b0;

  lcd_refresh_if lcd();

  lcd_refresh #(
    .POWERUP_CYC(PW), .INIT_LONG_CYC(IL), .INIT_SHORT_CYC(IS), .E_PULSE_CYC(EP),
    .NIBBLE_GAP_CYC(GP), .CMD_CYC(CC), .CLEAR_CYC(CL)
  ) dut (
    .CCLK(CCLK),
    .rst_n(rst_n),
    .lcd(lcd)
  );

  always #5 CCLK = ~CCLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rel   = 0;

  always @(posedge CCLK) cyc <= cyc + 1;

  logic [4:0] obs_nib[$];
  int         obs_t[$];
  int         bf_q[$];
  int         dn_q[$];
  logic [4:0] exp_nib[$];
  int         exp_t[$];
  int         model_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Panel-side monitor: nibble latch points, E pulse width, busy falls and done pulses.
  logic       prev_e, prev_busy, prev_done;
  int         hi_cnt;
  logic [4:0] rise_val;
  always @(negedge CCLK) begin
    if (!rst_n) begin
      prev_e = 1'b0; prev_busy = 1'b1; prev_done = 1'b0; hi_cnt = 0;
    end else begin
      check("lcdrw", lcd.LCDRW, 0);
      if (lcd.LCDE && !prev_e) begin
        rise_val = {lcd.LCDRS, lcd.LCDDAT};
        obs_nib.push_back(rise_val);
        obs_t.push_back(cyc - rel);
        hi_cnt = 0;
      end
      if (lcd.LCDE) hi_cnt++;
      if (!lcd.LCDE && prev_e) begin
        check("e_width", hi_cnt, EP);
        check("nibble_hold", {lcd.LCDRS, lcd.LCDDAT}, rise_val);
      end
      if (prev_busy && !lcd.busy) bf_q.push_back(cyc - rel);
      if (lcd.done) begin
        dn_q.push_back(cyc - rel);
        check("done_one_cycle", prev_done, 0);
      end
      prev_e = lcd.LCDE; prev_busy = lcd.busy; prev_done = lcd.done;
    end
  end

  // Reference model: each write is a nibble list plus a post-write wait, laid out on a timeline.
  task automatic add_write(input logic rs, input logic [7:0] b, input bit single, input int w);
    exp_nib.push_back({rs, b[7:4]});
    exp_t.push_back(model_t + 1);
    if (!single) begin
      exp_nib.push_back({rs, b[3:0]});
      exp_t.push_back(model_t + N + 1);
    end
    model_t += (single ? N : 2 * N) + w;
  endtask

  task automatic add_byte(input logic rs, input logic [7:0] b);
    add_write(rs, b, 1'b0, (!rs && b == 8'h01) ? CL : CC);
  endtask

  task automatic add_init();
    model_t = PW;
    add_write(1'b0, 8'h30, 1'b1, IL);
    add_write(1'b0, 8'h30, 1'b1, IS);
    add_write(1'b0, 8'h30, 1'b1, IS);
    add_write(1'b0, 8'h20, 1'b1, CC);
    add_byte(1'b0, 8'h28);
    add_byte(1'b0, 8'h06);
    add_byte(1'b0, 8'h0C);
    add_byte(1'b0, 8'h01);
  endtask

  task automatic add_refresh(input logic [255:0] f);
    add_byte(1'b0, 8'h80);
    for (int c = 0; c < 16; c++) add_byte(1'b1, f[8*(31-c) +: 8]);
    add_byte(1'b0, 8'hC0);
    for (int c = 16; c < 32; c++) add_byte(1'b1, f[8*(31-c) +: 8]);
  endtask

  task automatic cmp_nibbles(input string tag);
    int b0;
    check({tag, "_count"}, obs_nib.size(), exp_nib.size());
    for (int i = 0; i < exp_nib.size() && i < obs_nib.size(); i++) begin
      b0 = bad;
      check({tag, "_nibble"}, obs_nib[i], exp_nib[i]);
      check({tag, "_time"}, obs_t[i], exp_t[i]);
      if (bad != b0) break;
    end
  endtask

  task automatic clear_all();
    obs_nib.delete(); obs_t.delete(); bf_q.delete(); dn_q.delete();
    exp_nib.delete(); exp_t.delete();
  endtask

  task automatic wait_done(input int n, input int bound, input string tag);
    int i = 0;
    while (dn_q.size() < n && i < bound) begin @(negedge CCLK); i++; end
    check(tag, dn_q.size() >= n, 1);
  endtask

  task automatic wait_bf(input int n, input int bound, input string tag);
    int i = 0;
    while (bf_q.size() < n && i < bound) begin @(negedge CCLK); i++; end
    check(tag, bf_q.size() >= n, 1);
  endtask

  task automatic pulse_cls(output int p);
    p = cyc - rel;
    lcd.cls = 1'b1;
    @(negedge CCLK);
    lcd.cls = 1'b0;
  endtask

  function automatic logic [255:0] rand_frame();
    logic [255:0] f;
    for (int i = 0; i < 32; i++) f[8*i +: 8] = 8'($urandom_range(0, 255));
    return f;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lcde"}, lcd.LCDE, 0);
    check({tag, "_lcdrs"}, lcd.LCDRS, 0);
    check({tag, "_lcdrw"}, lcd.LCDRW, 0);
    check({tag, "_lcddat"}, lcd.LCDDAT, 0);
    check({tag, "_busy"}, lcd.busy, 1);
    check({tag, "_done"}, lcd.done, 0);
  endtask

  logic [255:0] f1, f2, f3, f4, fx;
  int p, e1, k, i;

  initial begin
    lcd.cls = 1'b0;
    lcd.strdata = '0;
    repeat (3) @(negedge CCLK);
    check_reset_outputs("reset");

    // Init with a strobe during init: refresh must follow busy's fall immediately.
    f1 = rand_frame();
    f1[8*20 +: 8] = 8'h01;
    lcd.strdata = f1;
    clear_all();
    rel = cyc;
    rst_n = 1'b1;
    while (cyc - rel < 30) @(negedge CCLK);
    pulse_cls(p);
    wait_bf(1, 400, "init_busy_fall_seen");
    check("no_done_during_init", dn_q.size(), 0);
    add_init();
    if (bf_q.size() > 0) check("init_busy_fall_time", bf_q[0], model_t);
    @(negedge CCLK);
    check("refresh_after_init", lcd.busy, 1);
    model_t += 1;
    add_refresh(f1);
    wait_done(1, 1000, "run1_done_seen");
    if (dn_q.size() > 0) check("run1_done_time", dn_q[0], model_t);
    repeat (300) @(negedge CCLK);
    cmp_nibbles("run1");
    check("run1_done_count", dn_q.size(), 1);
    check("run1_idle_busy", lcd.busy, 0);

    // Directed frame.
    clear_all();
    f2 = "0123456789abcdefFEDCBA9876543210";
    lcd.strdata = f2;
    pulse_cls(p);
    model_t = p + 1;
    add_refresh(f2);
    wait_done(1, 1000, "run2_done_seen");
    if (dn_q.size() > 0) check("run2_done_latency", dn_q[0] - (p + 1), 34 * (2 * N + CC));
    repeat (50) @(negedge CCLK);
    cmp_nibbles("run2");

    // Snapshot isolation and collapsed pending strobes.
    clear_all();
    f3 = rand_frame();
    fx = {32{8'h58}};
    lcd.strdata = f3;
    pulse_cls(p);
    model_t = p + 1;
    add_refresh(f3);
    e1 = model_t;
    model_t += 1;
    add_refresh(fx);
    repeat (100) @(negedge CCLK);
    lcd.strdata = fx;
    pulse_cls(k);
    repeat (100) @(negedge CCLK);
    pulse_cls(k);
    repeat (60) @(negedge CCLK);
    pulse_cls(k);
    wait_done(2, 1500, "run3_done_seen");
    if (dn_q.size() >= 2) begin
      check("run3_done1_time", dn_q[0], e1);
      check("run3_done2_time", dn_q[1], model_t);
    end
    repeat (700) @(negedge CCLK);
    cmp_nibbles("run3");
    check("run3_done_count", dn_q.size(), 2);
    check("run3_idle_busy", lcd.busy, 0);

    // Asynchronous reset while E is high, with a refresh pending.
    clear_all();
    f4 = rand_frame();
    lcd.strdata = f4;
    pulse_cls(p);
    repeat (20) @(negedge CCLK);
    pulse_cls(p);
    k = $urandom_range(3, 60);
    i = 0;
    while (!(obs_nib.size() >= k && lcd.LCDE) && i < 2000) begin @(negedge CCLK); i++; end
    check("mid_nibble_found", lcd.LCDE, 1);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(negedge CCLK);
    clear_all();
    rel = cyc;
    rst_n = 1'b1;
    wait_bf(1, 400, "reinit_busy_fall_seen");
    add_init();
    if (bf_q.size() > 0) check("reinit_busy_fall_time", bf_q[0], model_t);
    repeat (700) @(negedge CCLK);
    cmp_nibbles("run4");
    check("run4_no_done", dn_q.size(), 0);
    check("run4_idle_busy", lcd.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcd_refresh.md
# lcd_refresh

Character-LCD writer for the lab board's 2x16 HD44780-style panel, driven in 4-bit write-only mode. It sits directly downstream of the CPU top-level status formatter. It consumes the 256-bit, 32-character ASCII frame plus the one-cycle `cls` refresh strobe, and drives LCDE/LCDRS/LCDRW/LCDDAT. It performs the power-on initialisation sequence, then on every strobe rewrites both display lines from a snapshot of the frame.

## Interface
- `POWERUP_CYC`, 750000: cycles waited after reset before the first init nibble (15 ms at 50 MHz).
- `INIT_LONG_CYC`, 205000: wait after the first init nibble (4.1 ms).
- `INIT_SHORT_CYC`, 5000: wait after the second and third init nibbles (100 us).
- `E_PULSE_CYC`, 12: cycles LCDE is held high per nibble.
- `NIBBLE_GAP_CYC`, 50: cycles LCDE is held low after each falling edge.
- `CMD_CYC`, 2000: post-byte wait (40 us).
- `CLEAR_CYC`, 82000: post-byte wait for command 0x01 (1.64 ms).
- `CCLK  in  1`: board clock; all state is updated on the rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `cls  in  1`: refresh strobe, sampled every cycle.
- `strdata  in  256`: frame. [255:248] is line 1 column 0, through [135:128] for line 1 column 15. [127:120] is line 2 column 0, through [7:0] for line 2 column 15.
- `LCDE  out  1`: panel enable.
- `LCDRS  out  1`: 0 for command, 1 for data.
- `LCDRW  out  1`: tied 0 (write only).
- `LCDDAT  out  4`: nibble bus.
- `busy  out  1`: 1 while initialising or refreshing.
- `done  out  1`: one-cycle pulse at the end of each refresh.

## Operation
- Reset values: LCDE=0, LCDRS=0, LCDRW=0, LCDDAT=0, busy=1, done=0, pending=0, FSM=PWRUP, all counters 0.
- FSM states: PWRUP → INIT_NIB → INIT_CFG → IDLE → REFRESH → IDLE.
- **PWRUP:** wait POWERUP_CYC.
- **INIT_NIB:** single-nibble command writes, RS=0:
  - 0x3, then wait INIT_LONG_CYC.
  - 0x3, then wait INIT_SHORT_CYC.
  - 0x3, then wait INIT_SHORT_CYC.
  - 0x2, then wait CMD_CYC.
- **INIT_CFG:** full command bytes 0x28, 0x06, 0x0C (each followed by CMD_CYC), then 0x01 (followed by CLEAR_CYC). Then busy←0 and go to IDLE.
- **IDLE:** if `cls`=1 or pending=1:
  - copy `strdata` into an internal 256-bit snapshot;
  - pending←0, busy←1, enter REFRESH.
- **REFRESH:** 34 bytes in fixed order:
  - cmd 0x80;
  - 16 data bytes, line 1 columns 0..15;
  - cmd 0xC0;
  - 16 data bytes, line 2 columns 0..15.
  - Each byte waits CMD_CYC after its second nibble.
  - After the last wait: busy←0, done=1 for one cycle, back to IDLE.
- Nibble write, three phases:
  - SETUP, 1 cycle: LCDDAT and LCDRS valid, LCDE=0.
  - HIGH, E_PULSE_CYC cycles: LCDE=1.
  - LOW, NIBBLE_GAP_CYC cycles: LCDE=0.
  - LCDDAT and LCDRS are held stable through all three phases.
- Byte write: high nibble [7:4], then low nibble [3:0], then the post-byte wait. The wait is CLEAR_CYC if the byte is command 0x01, else CMD_CYC.
- `cls` while busy=1 (init or refresh) sets pending. Multiple strobes collapse into one.
  - The in-progress refresh keeps using its snapshot.
  - Changes to `strdata` mid-refresh are not visible until the next snapshot.
- `cls` during the same cycle the FSM enters IDLE starts the refresh immediately; it is not lost.
- During waits, LCDDAT holds the last nibble and LCDE=0.
- `rst_n` low at any point, including mid-nibble with LCDE=1, does the following immediately (asynchronously): LCDE→0, all outputs and state return to reset values, snapshot and pending are discarded. Initialisation restarts from PWRUP after release.
- LCDRW is 0 under all conditions.

## Timing
- Nibble duration N = 1 + E_PULSE_CYC + NIBBLE_GAP_CYC.
- Byte duration B = 2N + post-byte wait.
- Refresh latency: the first SETUP cycle is the cycle after `cls` is sampled in IDLE. busy falls, and done pulses, exactly 34·(2N+CMD_CYC) cycles after that first SETUP cycle begins.
- Init: busy falls exactly as follows, counted from reset release:
  - POWERUP_CYC
  - + 4N + INIT_LONG_CYC + 2·INIT_SHORT_CYC + CMD_CYC
  - + 4·2N + 3·CMD_CYC + CLEAR_CYC.
- done is never asserted during init.
- Counters are sized to the largest parameter. Every wait counts exactly its parameter value, with no off-by-one.

## Test plan
- **Init sequence.** Params: POWERUP=20, INIT_LONG=10, INIT_SHORT=5, E=2, GAP=2, CMD=4, CLEAR=8 (N=5). Release reset.
  - LCDE rising-edge nibbles, all with RS=0, must be 3,3,3,2,2,8,0,6,0,C,0,1.
  - busy falls at cycle 20+20+10+10+4+40+12+8 = 124.
- **Single refresh.** Frame "0123456789abcdef" / "FEDCBA9876543210", pulse cls.
  - 68 nibbles: 8,0 (RS=0); then 3,0 … 6,6 (RS=1); then C,0 (RS=0); then line 2 nibbles.
  - done pulses exactly 34·14 = 476 cycles after the first SETUP cycle.
- **Snapshot and pending.**
  - Change strdata to all "X" and pulse cls three times mid-refresh.
  - The first refresh still emits the original characters.
  - Exactly one further refresh follows, emitting 0x58 ×32.
  - Then IDLE; no third refresh.
- **cls during init.** Pulse cls at cycle 30.
  - A refresh starts on the cycle immediately after busy falls from init.
- **Reset mid-nibble.** Assert rst_n=0 while LCDE=1 during refresh.
  - LCDE, LCDRS, LCDDAT, busy and done take reset values immediately.
  - After release, the full init sequence repeats with no leftover pending refresh.
- **LCDRW.** Check LCDRW=0 on every cycle of all of the above.
